// File: rtl/aes_pkg.sv
// Shared types, the FIPS-197 inverse S-box table and the FSM state enum for
// the AES inverse byte-substitution block.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    localparam byte_t INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte i sits at bits [127-8i -: 8], row i%4, column i/4; row r rotates right by r.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15 - (r + 4*c)) +: 8] = s[8*(15 - (r + 4*((c - r + 4) % 4))) +: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_s_box.sv
// Single-byte FIPS-197 inverse S-box: a purely combinational table lookup.
module inv_s_box
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// Iterative AES InvSubBytes: LANES bytes per clock over 16/LANES clocks.
// Define AES_INV_SHIFT_ROWS_EN to apply InvShiftRows to the state at capture.
module aes_inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [1:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and out_data is held while out_valid waits.

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [3:0] LAST_CNT = 4'(16 - LANES);
    localparam logic [3:0] CNT_STEP = 4'(LANES);

    fsm_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    state_t     work_q, work_d;
    state_t     captured;

    logic [3:0] lane_idx [LANES];
    byte_t      sub_in   [LANES];
    byte_t      sub_out  [LANES];

    always_comb begin
`ifdef AES_INV_SHIFT_ROWS_EN
        captured = inv_shift_rows(in_data);
`else
        captured = in_data;
`endif
    end

    // {~idx, 3'b000} is 8*(15-idx), the LSB of byte idx.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_idx[j] = cnt_q + 4'(j);
            sub_in[j]   = work_q[{~lane_idx[j], 3'b000} +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_s_box u_inv_s_box (
            .in_byte  (sub_in[g]),
            .out_byte (sub_out[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = captured;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < LANES; j++) begin
                    work_d[{~lane_idx[j], 3'b000} +: 8] = sub_out[j];
                end
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = work_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Directed bench for aes_inv_sub_bytes: three instances (LANES 4, 1, 16)
// checked against hand constants and a forward-S-box based reference model.
module tb_aes_inv_sub_bytes;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] in_data;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [127:0] out_data  [3];
    logic [1:0]   dbg_state [3];

    int lanes_of [3] = '{4, 1, 16};

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q[$];

    aes_inv_sub_bytes #(.LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .dbg_state(dbg_state[0])
    );
    aes_inv_sub_bytes #(.LANES(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .dbg_state(dbg_state[1])
    );
    aes_inv_sub_bytes #(.LANES(16)) u_dut_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .dbg_state(dbg_state[2])
    );

    // ---------------- reference model ----------------
    logic [7:0] fwd_sbox [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [127:0] fwd_sub_state(input logic [127:0] pre);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = fwd_sbox[pre[127-8*i -: 8]];
        return o;
    endfunction

    // Forward view of InvShiftRows: input byte (r,c) lands in column (c+r)%4.
    function automatic logic [127:0] model_isr(input logic [127:0] s);
        logic [7:0] b [16];
        logic [7:0] o [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[r + 4*((c + r) % 4)] = b[r + 4*c];
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
        return res;
    endfunction

    // Input is fwd_sub_state(pre); the correct inverse substitution yields pre.
    function automatic logic [127:0] model_expect(input logic [127:0] pre);
`ifdef AES_INV_SHIFT_ROWS_EN
        return model_isr(pre);
`else
        return pre;
`endif
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Accept one state on instance k, check latency, result and return to IDLE.
    task automatic send(input int k, input logic [127:0] data, input logic [127:0] exp, input string tag);
        int waited;
        int lat;
        logic [127:0] e;
        @(negedge clk);
        waited = 0;
        while (!in_ready[k] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready[k]) begin
            chk({tag, "_ready_timeout"}, 128'(in_ready[k]), 128'(1));
            return;
        end
        in_valid[k] = 1'b1;
        in_data     = data;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        in_data     = rand_state();
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid[k]) break;
            in_data = rand_state();
        end
        chk({tag, "_latency"}, 128'(lat), 128'(16 / lanes_of[k]));
        e = exp_q.pop_front();
        if (out_valid[k]) begin
            chk({tag, "_data"}, out_data[k], e);
            @(posedge clk);
            #1;
            chk({tag, "_ready_after"}, 128'({in_ready[k], out_valid[k]}), 128'(2'b10));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] vec_in;
        logic [127:0] vec_exp;
        logic [127:0] pre;
        int waited;

        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 3'b111;
        in_data   = '0;
        vec_in    = 128'h637C777B_F26B6FC5_3001672B_FED7AB76;
`ifdef AES_INV_SHIFT_ROWS_EN
        vec_exp   = 128'h000D0A07_04010E0B_0805020F_0C090603;
`else
        vec_exp   = 128'h00010203_04050607_08090A0B_0C0D0E0F;
`endif
        apply_reset();

        // Reset state
        @(negedge clk);
        chk("reset_in_ready",  128'(in_ready),  128'(3'b111));
        chk("reset_out_valid", 128'(out_valid), 128'(3'b000));
        chk("reset_out_data",  out_data[0],     128'h0);

        // All 0x63 -> all 0x00
        send(0, {16{8'h63}}, {16{8'h00}}, "all63");

        // Known-answer vector
        send(0, vec_in, vec_exp, "kat");

        // Backpressure in DONE
        out_ready[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data     = vec_in;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        waited = 0;
        while (!out_valid[0] && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("bp_reach_done", 128'(out_valid[0]), 128'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid[0] = 1'(i % 2);
            in_data     = rand_state();
            @(posedge clk);
            #1;
            chk("bp_data_stable", out_data[0], vec_exp);
            chk("bp_flags", 128'({in_ready[0], out_valid[0]}), 128'(2'b01));
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 128'({in_ready[0], out_valid[0]}), 128'(2'b10));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_no_second_accept", 128'({in_ready[0], out_valid[0]}), 128'(2'b10));
        end

        // Reset two cycles after accept discards the state
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data     = {16{8'h63}};
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_out_data", out_data[0], 128'h0);
        for (int i = 0; i < 8; i++) begin
            chk("midrst_no_valid", 128'({in_ready[0], out_valid[0]}), 128'(2'b10));
            @(negedge clk);
        end
        send(0, {16{8'h16}}, {16{8'hFF}}, "after_rst_16");

        // Sweep every byte value through every byte position on all three widths
        for (int v = 0; v < 256; v++) begin
            for (int i = 0; i < 16; i++) pre[127-8*i -: 8] = 8'((v + 17*i) % 256);
            for (int k = 0; k < 3; k++) begin
                send(k, fwd_sub_state(pre), model_expect(pre), $sformatf("sweep_l%0d_v%0d", lanes_of[k], v));
            end
        end

        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_sub_bytes.md
AES_INV_SUB_BYTES -- requirements
Module: aes_inv_sub_bytes

Interface
REQ-001 Parameter LANES, default 4, number of bytes substituted per clock; legal values 1, 2, 4, 8, 16; any other value SHALL fail elaboration.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  in_data is valid.
REQ-005 in_ready  output  1  block can accept a state.
REQ-006 in_data  input  128  AES state; byte i = bits [127-8i -: 8], row i%4, column i/4.
REQ-007 out_valid  output  1  out_data holds a finished result.
REQ-008 out_ready  input  1  consumer accepts out_data.
REQ-009 out_data  output  128  InvSubBytes result, same byte order as in_data.

Function
REQ-010 FSM states SHALL be IDLE, BUSY and DONE.
REQ-011 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-012 IDLE: on in_valid && in_ready, capture in_data into the working register, clear the lane counter and go to BUSY.
REQ-013 BUSY: each clock replaces LANES bytes, lowest byte index first, with inv_sbox(byte); the counter advances by LANES.
REQ-014 After 16/LANES BUSY clocks the FSM SHALL enter DONE; out_valid rises on the (16/LANES)th edge after the accept edge (4 for LANES=4).
REQ-015 DONE: out_data SHALL hold stable until out_valid && out_ready, then return to IDLE on that edge.
REQ-016 No accept in DONE; throughput is one state per 16/LANES+2 clocks minimum.
REQ-017 in_valid in BUSY or DONE SHALL be ignored; in_data changes outside the accept edge SHALL not affect the result.
REQ-018 inv_sbox SHALL be the exact FIPS-197 inverse S-box: inv_sbox(sbox(x)) = x for all 256 x.
REQ-019 out_data SHALL equal the working register; its content in IDLE/BUSY is don't-care but deterministic.

Reset
REQ-020 With rst_n=0 at a clock edge: FSM to IDLE, counter 0, working register 0, out_valid 0; in_ready reads 1 from the following cycle.
REQ-021 Reset in BUSY or DONE SHALL discard the partial or pending result with no output handshake.

Configuration
REQ-022 Macro AES_INV_SHIFT_ROWS_EN defined: the captured state SHALL be permuted by InvShiftRows (out[r][c] = in[r][(c-r) mod 4]) before substitution, so out_data = InvSubBytes(InvShiftRows(in_data)); latency unchanged.
REQ-023 Macro undefined: no permutation; out_data = InvSubBytes(in_data).

Structure
REQ-024 Package aes_pkg SHALL hold byte_t (8 bit), state_t (128 bit), the 256-entry INV_SBOX constant and the FSM state enum.
REQ-025 Sub-module inv_s_box (8-bit in, 8-bit out, combinational lookup of aes_pkg INV_SBOX) SHALL be instantiated LANES times.

Verification
REQ-026 Reset, then in_data = 16 bytes of 0x63, out_ready=1 -> out_valid after 4 edges, out_data = all 0x00, in_ready back to 1 the next cycle.
REQ-027 in_data = 637C777B_F26B6FC5_3001672B_FED7AB76, macro off -> out_data = 00010203_04050607_08090A0B_0C0D0E0F.
REQ-028 Same input, AES_INV_SHIFT_ROWS_EN on -> out_data = 000D0A07_04010E0B_0805020F_0C090603.
REQ-029 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid/in_data -> out_data stable, in_ready 0, no second accept; result delivered on out_ready=1.
REQ-030 rst_n=0 for one edge two cycles after accept -> out_valid never rises; a following input of all 0x16 returns all 0xFF.
REQ-031 Sweep all 256 byte values through every lane position for LANES = 1, 4, 16 -> out_data matches the reference model; latency = 16/LANES.
